// File: rtl/tag_alloc_ctrl.sv
// Tag allocation controller: tracks N in-use IDs, grants the next free one
// round-robin with zero latency, and supports drain/flush plus hard clear.
module tag_alloc_ctrl #(
  parameter int unsigned N = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_req,
  output logic                 alloc_gnt,
  output logic [$clog2(N)-1:0] alloc_id,
  input  logic                 free_vld,
  input  logic [$clog2(N)-1:0] free_id,
  input  logic                 flush_req,
  output logic                 flush_done,
  input  logic                 clear,
  output logic [N-1:0]         busy_r,
  output logic [$clog2(N):0]   count_r,
  output logic                 empty_r,
  output logic                 full_r,
  output logic                 err_r
);

  localparam int unsigned W  = $clog2(N);
  localparam int unsigned CW = W + 1;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    busy_q, busy_d;
  logic [CW-1:0]   count_q, count_d;
  logic [W-1:0]    ptr_q, ptr_d;
  logic            empty_q, empty_d;
  logic            full_q, full_d;
  logic            err_q, err_d;
  logic            flush_done_q, flush_done_d;

  logic [W-1:0]    sel_id;
  logic            sel_found;
  int unsigned     scan_idx;
  logic [N-1:0]    free_dec;
  logic            free_ok;
  logic            free_err;

  // Scan ptr, ptr+1, ... wrapping modulo N rather than modulo 2^W.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    scan_idx  = 0;
    for (int unsigned k = 0; k < N; k++) begin
      scan_idx = 32'(ptr_q) + k;
      if (scan_idx >= N) scan_idx = scan_idx - N;
      if (!sel_found && !busy_q[W'(scan_idx)]) begin
        sel_found = 1'b1;
        sel_id    = W'(scan_idx);
      end
    end
  end

  // Out-of-range free IDs decode to all-zero and so count as a bad free.
  always_comb begin
    free_dec = '0;
    for (int unsigned k = 0; k < N; k++) begin
      free_dec[k] = (free_id == W'(k));
    end
    free_ok  = free_vld & ~clear & (|(free_dec & busy_q));
    free_err = free_vld & ~clear & ~(|(free_dec & busy_q));
  end

  always_comb begin
    busy_d = busy_q;
    if (clear) begin
      busy_d = '0;
    end else begin
      if (free_ok)   busy_d = busy_q & ~free_dec;
      if (alloc_gnt) busy_d[sel_id] = 1'b1;
    end
    count_d = clear ? '0 : (count_q + CW'(alloc_gnt) - CW'(free_ok));
    empty_d = (count_d == '0);
    full_d  = (count_d == CW'(N));
    err_d   = err_q | free_err;
    ptr_d   = ptr_q;
    if (clear || state_q == S_DONE) begin
      ptr_d = '0;
    end else if (alloc_gnt) begin
      ptr_d = (sel_id == W'(N - 1)) ? '0 : sel_id + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (flush_req) state_d = S_DRAIN;
      S_DRAIN: if (count_d == '0) state_d = S_DONE;
      S_DONE:  state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
    if (clear) state_d = S_RUN;
  end

  always_comb begin
    alloc_gnt    = alloc_req & ~full_q & (state_q == S_RUN) & ~clear;
    alloc_id     = sel_id;
    flush_done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_RUN;
      busy_q       <= '0;
      count_q      <= '0;
      ptr_q        <= '0;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
      err_q        <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      count_q      <= count_d;
      ptr_q        <= ptr_d;
      empty_q      <= empty_d;
      full_q       <= full_d;
      err_q        <= err_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign busy_r     = busy_q;
  assign count_r    = count_q;
  assign empty_r    = empty_q;
  assign full_r     = full_q;
  assign err_r      = err_q;
  assign flush_done = flush_done_q;

endmodule

// File: tb/tb_tag_alloc_ctrl.sv
// Directed self-checking bench for tag_alloc_ctrl with N=4; expected grants
// go through a scoreboard queue, registered state is checked against constants.
module tb_tag_alloc_ctrl;

  localparam int unsigned N = 4;

  logic       clk;
  logic       rst;
  logic       alloc_req;
  logic       alloc_gnt;
  logic [1:0] alloc_id;
  logic       free_vld;
  logic [1:0] free_id;
  logic       flush_req;
  logic       flush_done;
  logic       clear;
  logic [3:0] busy_r;
  logic [2:0] count_r;
  logic       empty_r;
  logic       full_r;
  logic       err_r;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       gnt;
    logic [1:0] id;
  } exp_t;

  exp_t sb[$];

  tag_alloc_ctrl #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .alloc_req  (alloc_req),
    .alloc_gnt  (alloc_gnt),
    .alloc_id   (alloc_id),
    .free_vld   (free_vld),
    .free_id    (free_id),
    .flush_req  (flush_req),
    .flush_done (flush_done),
    .clear      (clear),
    .busy_r     (busy_r),
    .count_r    (count_r),
    .empty_r    (empty_r),
    .full_r     (full_r),
    .err_r      (err_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check grant outputs before the edge,
  // then return 1 time unit after the edge for registered checks.
  task automatic cyc(input string tag, input logic req, input logic fv, input logic [1:0] fid,
                     input logic fl, input logic clr, input logic eg, input logic [1:0] eid);
    exp_t e;
    alloc_req = req;
    free_vld  = fv;
    free_id   = fid;
    flush_req = fl;
    clear     = clr;
    sb.push_back('{gnt: eg, id: eid});
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_gnt"}, 32'(alloc_gnt), 32'(e.gnt));
      if (e.gnt) chk({tag, "_id"}, 32'(alloc_id), 32'(e.id));
    end
    @(posedge clk);
    #1;
    alloc_req = 1'b0;
    free_vld  = 1'b0;
    flush_req = 1'b0;
    clear     = 1'b0;
  endtask

  task automatic do_reset(input logic req, input logic fv);
    rst       = 1'b1;
    alloc_req = req;
    free_vld  = fv;
    free_id   = 2'd0;
    flush_req = 1'b0;
    clear     = 1'b0;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    alloc_req = 1'b0;
    free_vld  = 1'b0;
  endtask

  task automatic chk_state(input string tag, input logic [3:0] busy, input logic [2:0] cnt,
                           input logic emp, input logic ful, input logic err, input logic fd);
    chk({tag, "_busy"},  32'(busy_r),     32'(busy));
    chk({tag, "_count"}, 32'(count_r),    32'(cnt));
    chk({tag, "_empty"}, 32'(empty_r),    32'(emp));
    chk({tag, "_full"},  32'(full_r),     32'(ful));
    chk({tag, "_err"},   32'(err_r),      32'(err));
    chk({tag, "_fdone"}, 32'(flush_done), 32'(fd));
  endtask

  initial begin
    rst = 1'b1; alloc_req = 1'b0; free_vld = 1'b0; free_id = '0;
    flush_req = 1'b0; clear = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk_state("reset", 4'b0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Fill: four grants then a blocked request
    cyc("fill0", 1, 0, 0, 0, 0, 1, 2'd0);
    cyc("fill1", 1, 0, 0, 0, 0, 1, 2'd1);
    cyc("fill2", 1, 0, 0, 0, 0, 1, 2'd2);
    cyc("fill3", 1, 0, 0, 0, 0, 1, 2'd3);
    chk_state("full", 4'b1111, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("fill4", 1, 0, 0, 0, 0, 0, 2'd0);
    chk_state("full_hold", 4'b1111, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0);

    // Round-robin wrap
    do_reset(0, 0);
    cyc("rr0", 1, 0, 0, 0, 0, 1, 2'd0);
    cyc("rr1", 1, 0, 0, 0, 0, 1, 2'd1);
    cyc("rr2", 1, 0, 0, 0, 0, 1, 2'd2);
    cyc("rr_free1", 0, 1, 2'd1, 0, 0, 0, 2'd0);
    chk_state("rr_after_free", 4'b0101, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("rr3", 1, 0, 0, 0, 0, 1, 2'd3);
    cyc("rr_wrap", 1, 0, 0, 0, 0, 1, 2'd1);
    chk_state("rr_end", 4'b1111, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0);

    // Alloc and free in the same cycle, then no-bypass wrap back to tag 0
    do_reset(0, 0);
    cyc("af0", 1, 0, 0, 0, 0, 1, 2'd0);
    cyc("af1", 1, 0, 0, 0, 0, 1, 2'd1);
    cyc("af_both", 1, 1, 2'd0, 0, 0, 1, 2'd2);
    chk_state("af_after", 4'b0110, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("af3", 1, 0, 0, 0, 0, 1, 2'd3);
    cyc("af_wrap0", 1, 0, 0, 0, 0, 1, 2'd0);
    chk_state("af_end", 4'b1111, 3'd4, 1'b0, 1'b1, 1'b0, 1'b0);

    // Drain with three busy tags
    do_reset(0, 0);
    cyc("dr_a0", 1, 0, 0, 0, 0, 1, 2'd0);
    cyc("dr_a1", 1, 0, 0, 0, 0, 1, 2'd1);
    cyc("dr_a2", 1, 0, 0, 0, 0, 1, 2'd2);
    cyc("dr_flush", 0, 0, 0, 1, 0, 0, 2'd0);
    cyc("dr_f0", 1, 1, 2'd0, 0, 0, 0, 2'd0);
    chk_state("dr_s0", 4'b0110, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("dr_f1", 1, 1, 2'd1, 1, 0, 0, 2'd0);
    chk_state("dr_s1", 4'b0100, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("dr_f2", 1, 1, 2'd2, 0, 0, 0, 2'd0);
    chk_state("dr_done", 4'b0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc("dr_donecyc", 1, 0, 0, 0, 0, 0, 2'd0);
    chk("dr_fdone_once", 32'(flush_done), 32'd0);
    cyc("dr_regrant", 1, 0, 0, 0, 0, 1, 2'd0);
    chk_state("dr_end", 4'b0001, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Double free, then clear mid-drain
    cyc("df_free2", 0, 1, 2'd2, 0, 0, 0, 2'd0);
    chk_state("df_after", 4'b0001, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc("cl_a1", 1, 0, 0, 0, 0, 1, 2'd1);
    cyc("cl_flush", 0, 0, 0, 1, 0, 0, 2'd0);
    cyc("cl_drain", 1, 0, 0, 0, 0, 0, 2'd0);
    cyc("cl_clear", 1, 1, 2'd0, 1, 1, 0, 2'd0);
    chk_state("cl_after", 4'b0000, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc("cl_run", 1, 0, 0, 0, 0, 1, 2'd0);
    chk_state("cl_end", 4'b0001, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset mid-drain
    cyc("rs_flush", 0, 0, 0, 1, 0, 0, 2'd0);
    cyc("rs_drain", 1, 0, 0, 0, 0, 0, 2'd0);
    do_reset(1, 1);
    chk_state("rs_after", 4'b0000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc("rs_idle0", 0, 0, 0, 0, 0, 0, 2'd0);
    chk("rs_fdone0", 32'(flush_done), 32'd0);
    cyc("rs_idle1", 0, 0, 0, 0, 0, 0, 2'd0);
    chk("rs_fdone1", 32'(flush_done), 32'd0);
    cyc("rs_grant", 1, 0, 0, 0, 0, 1, 2'd0);
    chk_state("rs_end", 4'b0001, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
